mem_burst_ctrl: RTL and testbench

//  Upstream sequencer for the 16x8 single-port sync-read memory (adr/we/dat_w/dat_r).

---
 rtl/mem_burst_pkg.sv | 13 +
 rtl/mem_burst_rdbuf.sv | 45 ++++
 rtl/mem_burst_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_burst_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the burst sequencer that drives the 16x8 sync-read memory.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/mem_burst_rdbuf.sv
// Two-entry read-data FIFO that absorbs the memory's one-cycle read latency.
module mem_burst_rdbuf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_cnt;

    // A push while full is only ever issued together with a pop, so the slot being
    // overwritten is the head that leaves this same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (i_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rp];
    assign o_count = r_cnt;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst command sequencer: turns write/read burst commands into one memory beat per cycle.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_dat_w,
    input  logic [DW-1:0] mem_dat_r
);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_issue_rem;
    logic [LW-1:0] r_pop_rem;
    logic          r_inflight;
    logic          r_done;
    logic [AW-1:0] r_mem_adr;

    logic          w_cmd_fire;
    logic          w_cmd_rd;
    logic          w_wr_beat;
    logic          w_pop;
    logic          w_room;
    logic          w_rd_issue;
    logic [AW-1:0] w_issue_adr;
    logic          w_buf_valid;
    logic [DW-1:0] w_buf_data;
    logic [1:0]    w_buf_cnt;

    assign cmd_ready  = rst && (r_state == IDLE);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_cmd_rd   = w_cmd_fire && (cmd_op == OP_RD) && (cmd_len != '0);
    assign w_wr_beat  = (r_state == WR) && wr_valid;
    assign w_pop      = w_buf_valid && rd_ready;

    // A pop this cycle frees a slot, which keeps a full-rate stream at one beat per cycle.
    assign w_room = ({1'b0, w_buf_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});

    // The first read address goes out in the handshake cycle itself so that data is
    // ready two cycles after the command.
    assign w_rd_issue  = w_cmd_rd || ((r_state == RD) && (r_issue_rem != '0) && w_room);
    assign w_issue_adr = w_cmd_rd ? cmd_addr : r_addr;

    assign mem_we    = w_wr_beat;
    assign mem_adr   = w_wr_beat ? r_addr : (w_rd_issue ? w_issue_adr : r_mem_adr);
    assign mem_dat_w = w_wr_beat ? wr_data : '0;
    assign wr_ready  = (r_state == WR);
    assign rd_valid  = w_buf_valid;
    assign rd_data   = w_buf_data;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_cmd_fire && (cmd_len != '0)) w_next = (cmd_op == OP_RD) ? RD : WR;
            WR:   if (w_wr_beat && (r_issue_rem == LW'(1))) w_next = IDLE;
            RD:   if (w_pop && (r_pop_rem == LW'(1))) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_issue_rem <= '0;
            r_pop_rem   <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
            r_mem_adr   <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_issue;
            r_done     <= (w_cmd_fire && (cmd_len == '0))
                       || (w_wr_beat && (r_issue_rem == LW'(1)))
                       || ((r_state == RD) && w_pop && (r_pop_rem == LW'(1)));
            if (w_wr_beat || w_rd_issue) begin
                r_mem_adr <= mem_adr;
            end
            if (w_cmd_fire) begin
                if (w_cmd_rd) begin
                    r_addr      <= cmd_addr + AW'(1);
                    r_issue_rem <= cmd_len - LW'(1);
                end else begin
                    r_addr      <= cmd_addr;
                    r_issue_rem <= cmd_len;
                end
                r_pop_rem <= cmd_len;
            end else begin
                if (w_wr_beat || w_rd_issue) begin
                    r_addr      <= r_addr + AW'(1);
                    r_issue_rem <= r_issue_rem - LW'(1);
                end
                if (w_pop) begin
                    r_pop_rem <= r_pop_rem - LW'(1);
                end
            end
        end
    end

    mem_burst_rdbuf #(.DW(DW)) u_rdbuf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (mem_dat_r),
        .i_pop   (w_pop),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_count (w_buf_cnt)
    );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with the 16x8 memory and a queue-based reference model.
module tb_mem_burst_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_dat_w;
    logic [DW-1:0] mem_dat_r;

    always #5 clk = ~clk;

    mem_burst_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .busy(busy),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r)
    );

    // 16x8 single-port synchronous-read memory
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_dat_w;
        mem_dat_r <= mem[mem_adr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] mdl [16];
    wr_t           exp_wr [$];
    logic [DW-1:0] exp_rd [$];
    logic [DW-1:0] rd_log [$];
    logic          in_wr = 1'b0;
    logic          mon_en = 1'b0;
    int            ndone = 0;
    int            exp_done = 0;
    int            errs = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model queues
    wr_t           cw;
    logic [DW-1:0] cd;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_ready", wr_ready, in_wr);
            chk("mem_we", mem_we, in_wr && wr_valid);
            if (mem_we) begin
                if (exp_wr.size() == 0) chk("wr_extra_beat", exp_wr.size(), 1);
                else begin
                    cw = exp_wr.pop_front();
                    chk("wr_adr", mem_adr, cw.a);
                    chk("wr_dat", mem_dat_w, cw.d);
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) chk("rd_extra_beat", exp_rd.size(), 1);
                else begin
                    cd = exp_rd.pop_front();
                    chk("rd_data", rd_data, cd);
                end
                rd_log.push_back(rd_data);
            end
            if (done) ndone++;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_rd_data", rd_data, 0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready_after", cmd_ready, 1);
        mon_en = 1'b1;
        cyc();
    endtask

    task automatic send_cmd(input logic op, input logic [AW-1:0] addr, input int len);
        int t;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = LW'(len);
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 20) begin
            t++;
            @(negedge clk);
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int len,
                            input logic [DW-1:0] base, input logic [DW-1:0] step, input bit gaps);
        logic [DW-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = base + DW'(i) * step;
            exp_wr.push_back({AW'(addr + AW'(i)), d});
            mdl[AW'(addr + AW'(i))] = d;
        end
        send_cmd(1'b0, addr, len);
        in_wr = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 2 == 1)) begin
                wr_valid = 1'b0;
                @(negedge clk);
                chk("gap_mem_we", mem_we, 0);
                cyc();
            end
            wr_valid = 1'b1;
            wr_data  = base + DW'(i) * step;
            cyc();
        end
        wr_valid = 1'b0;
        in_wr    = 1'b0;
        @(negedge clk);
        chk("wr_done", done, 1);
        chk("wr_busy_after", busy, 0);
        chk("wr_cmd_ready_after", cmd_ready, 1);
        exp_done++;
        cyc();
    endtask

    // mode 0: rd_ready always 1; mode 1: rd_ready pattern 1,0,0 repeating
    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input int mode,
                            output int first_k, output int end_k);
        int k;
        int pops;
        for (int i = 0; i < len; i++) exp_rd.push_back(mdl[AW'(addr + AW'(i))]);
        rd_log.delete();
        rd_ready = 1'b1;
        send_cmd(1'b1, addr, len);
        first_k = -1;
        k = 0;
        pops = 0;
        while (pops < len && k < 300) begin
            @(negedge clk);
            if (rd_valid && first_k < 0) first_k = k;
            if (rd_valid && rd_ready) pops++;
            cyc();
            k++;
            rd_ready = (mode == 0) || (k % 3 == 0);
        end
        chk("rd_beats", pops, len);
        @(negedge clk);
        chk("rd_done", done, 1);
        chk("rd_busy_after", busy, 0);
        exp_done++;
        cyc();
        rd_ready = 1'b0;
        end_k = k;
    endtask

    initial begin
        int fk;
        int ek;
        int t;
        do_reset();

        // Full-memory preload, length 2**AW
        wr_burst(4'd0, 16, 8'h80, 8'h01, 1'b0);
        chk("pre_mem15", mem[15], 8'h8F);

        // 1: write addr 3 len 4
        wr_burst(4'd3, 4, 8'hA0, 8'h01, 1'b0);
        chk("t1_mem3", mem[3], 8'hA0);
        chk("t1_mem6", mem[6], 8'hA3);
        chk("t1_mem7", mem[7], 8'h87);

        // 2: read back at full rate
        rd_burst(4'd3, 4, 0, fk, ek);
        chk("t2_first_lat", fk, 1);
        chk("t2_consecutive", ek, 5);
        chk("t2_nbeats", rd_log.size(), 4);
        chk("t2_beat0", rd_log[0], 8'hA0);
        chk("t2_beat3", rd_log[3], 8'hA3);

        // 3: wrap-around write and read
        wr_burst(4'd14, 4, 8'h11, 8'h11, 1'b0);
        chk("t3_mem14", mem[14], 8'h11);
        chk("t3_mem15", mem[15], 8'h22);
        chk("t3_mem0", mem[0], 8'h33);
        chk("t3_mem1", mem[1], 8'h44);
        rd_burst(4'd14, 4, 0, fk, ek);
        chk("t3_rd0", rd_log[0], 8'h11);
        chk("t3_rd3", rd_log[3], 8'h44);

        // 4: backpressured read of 8
        rd_burst(4'd3, 8, 1, fk, ek);
        chk("t4_nbeats", rd_log.size(), 8);
        chk("t4_beat4", rd_log[4], 8'h87);
        chk("t4_beat7", rd_log[7], 8'h8A);

        // 6: zero-length command, then a write with gaps
        send_cmd(1'b0, 4'd5, 0);
        @(negedge clk);
        chk("t6_zl_done", done, 1);
        chk("t6_zl_busy", busy, 0);
        exp_done++;
        cyc();
        @(negedge clk);
        chk("t6_zl_done_pulse", done, 0);
        cyc();
        wr_burst(4'd8, 4, 8'h50, 8'h01, 1'b1);
        chk("t6_mem8", mem[8], 8'h50);
        chk("t6_mem11", mem[11], 8'h53);

        // 5: reset in the middle of a read after 3 pops
        for (int i = 0; i < 8; i++) exp_rd.push_back(mdl[AW'(4 + i)]);
        rd_log.delete();
        rd_ready = 1'b1;
        send_cmd(1'b1, 4'd4, 8);
        t = 0;
        while (rd_log.size() < 3 && t < 50) begin
            @(negedge clk);
            #1;
            if (rd_log.size() < 3) cyc();
            t++;
        end
        chk("t5_pre_pops", rd_log.size(), 3);
        cyc();
        rst = 1'b0;
        rd_ready = 1'b0;
        exp_rd.delete();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rd_valid", rd_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        cyc();
        rd_burst(4'd0, 1, 0, fk, ek);
        chk("t5_mem0", rd_log[0], 8'h33);

        repeat (4) cyc();
        chk("done_total", ndone, exp_done);
        chk("wr_q_drained", exp_wr.size(), 0);
        chk("rd_q_drained", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
